// File: rtl/mux_21_pkg.sv
// Shared constants and the default data-word type for the mux_21 block.
package mux_21_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] data_t;

endpackage : mux_21_pkg

// File: rtl/mux_21_swcnt.sv
// Saturating counter of select transitions: compares S1 against its value
// from the previous cycle and counts each edge where they differ.
module mux_21_swcnt
    import mux_21_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_prev_d, s1_prev_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s1_prev_d = s1;
        cnt_d     = cnt_q;
        if ((s1 != s1_prev_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous so it wins over any increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_prev_q <= s1_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : mux_21_swcnt

// File: rtl/mux_21.sv
// 2:1 multiplexer with combinational output Y and registered copy YQ.
// Define MUX_21_SWCNT_EN to add the SWITCH_CNT select-transition counter.
module mux_21
    import mux_21_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             S1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] Y,
`ifdef MUX_21_SWCNT_EN
    output logic [CNT_W-1:0] SWITCH_CNT,
`endif
    output logic [WIDTH-1:0] YQ
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] yq_d, yq_q;

    // The conditional operator merges D0/D1 bitwise when S1 is X/Z.
    always_comb begin
        y_d  = S1 ? D1 : D0;
        yq_d = y_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            yq_q <= '0;
        end else begin
            yq_q <= yq_d;
        end
    end

    assign Y  = y_d;
    assign YQ = yq_q;

`ifdef MUX_21_SWCNT_EN
    mux_21_swcnt #(
        .CNT_W (CNT_W)
    ) u_swcnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .s1    (S1),
        .count (SWITCH_CNT)
    );
`endif

endmodule : mux_21

// File: tb/tb_mux_21.sv
// Directed self-checking bench for mux_21 (1-bit and 8-bit) and its transition counter.
module tb_mux_21;
    import mux_21_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       s1;
    data_t      d0_1, d1_1, y_1, yq_1;
    logic [7:0] d0_8, d1_8, y_8, yq_8;
    logic [1:0] cnt_ref;
`ifdef MUX_21_SWCNT_EN
    logic [1:0] swcnt_1;
    logic [7:0] swcnt_8;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_21 #(.WIDTH(1), .CNT_W(2)) dut_1 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .S1         (s1),
        .D0         (d0_1),
        .D1         (d1_1),
        .Y          (y_1),
`ifdef MUX_21_SWCNT_EN
        .SWITCH_CNT (swcnt_1),
`endif
        .YQ         (yq_1)
    );

    mux_21 #(.WIDTH(8), .CNT_W(8)) dut_8 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .S1         (s1),
        .D0         (d0_8),
        .D1         (d1_8),
        .Y          (y_8),
`ifdef MUX_21_SWCNT_EN
        .SWITCH_CNT (swcnt_8),
`endif
        .YQ         (yq_8)
    );

    // Counter checked directly too, so it is exercised in every build.
    mux_21_swcnt #(.CNT_W(2)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .s1    (s1),
        .count (cnt_ref)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] exp);
        check({tag, "_cnt"}, 32'(cnt_ref), 32'(exp));
`ifdef MUX_21_SWCNT_EN
        check({tag, "_swcnt"}, 32'(swcnt_1), 32'(exp));
`endif
    endtask

    // {S1,D0,D1} and the expected Y for the truth-table sweep
    logic [2:0] tt_vec [9] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                               3'b101, 3'b110, 3'b111, 3'b000};
    logic       tt_exp [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] tog_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_n = 1'b0;
        s1    = 1'b1;
        d0_1  = 1'b0;
        d1_1  = 1'b1;
        d0_8  = 8'h00;
        d1_8  = 8'hFF;
        #1;
        check("rst_y_comb", 32'(y_1), 32'd1);

        // Reset held two cycles: YQ and counters clear, Y stays live.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_yq", 32'(yq_1), 32'd0);
            check("rst_yq8", 32'(yq_8), 32'd0);
            check("rst_y", 32'(y_1), 32'd1);
            check_cnt("rst", 2'd0);
        end

        // Release: Y immediate, YQ one edge later; first edge counts S1=1.
        rst_n = 1'b1;
        #1;
        check("reg_y_now", 32'(y_1), 32'd1);
        check("reg_yq_before", 32'(yq_1), 32'd0);
        tick();
        check("reg_yq_after", 32'(yq_1), 32'd1);
        check_cnt("first_edge", 2'd1);

        // Reset overrides a transition in the same cycle.
        rst_n = 1'b0;
        s1    = 1'b0;
        tick();
        check_cnt("rst_override", 2'd0);
        check("rst_override_yq", 32'(yq_1), 32'd0);
        rst_n = 1'b1;

        // Data changes with S1 constant never count.
        for (int i = 0; i < 3; i++) begin
            d0_1 = ~d0_1;
            d1_1 = ~d1_1;
            tick();
            check_cnt("data_only", 2'd0);
        end

        // Toggle S1 each cycle: saturates at 3.
        for (int i = 0; i < 5; i++) begin
            s1 = ~s1;
            tick();
            check_cnt($sformatf("toggle%0d", i), tog_exp[i]);
        end

        // Truth-table sweep, each vector held 20 ns.
        for (int i = 0; i < 9; i++) begin
            logic [2:0] v;
            v    = tt_vec[i];
            s1   = v[2];
            d0_1 = v[1];
            d1_1 = v[0];
            #1;
            check($sformatf("tt_y%0d", i), 32'(y_1), 32'(tt_exp[i]));
            #9;
            @(posedge clk);
            #1;
            check($sformatf("tt_yq%0d", i), 32'(yq_1), 32'(tt_exp[i]));
        end

        // 8-bit datapath.
        d0_8 = 8'hA5;
        d1_8 = 8'h3C;
        s1   = 1'b0;
        #1;
        check("w8_y_d0", 32'(y_8), 32'hA5);
        s1 = 1'b1;
        #1;
        check("w8_y_d1", 32'(y_8), 32'h3C);
        tick();
        check("w8_yq", 32'(yq_8), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_21

// File: doc/mux_21.md
MUX_21 -- requirements
Module: mux_21

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the data width of D0, D1, Y and YQ.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of SWITCH_CNT.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 S1  input  1  SHALL be the select: 0 picks D0, 1 picks D1.
REQ-006 D0  input  WIDTH  SHALL be data input 0.
REQ-007 D1  input  WIDTH  SHALL be data input 1.
REQ-008 Y  output  WIDTH  SHALL be the combinational mux output.
REQ-009 YQ  output  WIDTH  SHALL be the registered copy of Y.
REQ-010 SWITCH_CNT  output  CNT_W  SHALL count S1 transitions; present only when MUX_21_SWCNT_EN is defined.

Function
REQ-011 Y SHALL equal D1 when S1=1 and D0 when S1=0, with zero-cycle latency.
REQ-012 Y SHALL follow input changes within the same time step, with no clock dependency.
REQ-013 In simulation, when S1 is X/Z, each bit of Y SHALL equal the common value of D0 and D1 where those bits agree, and X where they differ.
REQ-014 YQ SHALL load Y on every rising CLK edge while RST_N=1, giving one-cycle latency.
REQ-015 The block SHALL register S1 each cycle into an internal S1_prev.
REQ-016 SWITCH_CNT SHALL increment by 1 on each clock edge where S1 differs from S1_prev.
REQ-017 SWITCH_CNT SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-018 A D0/D1 change with S1 held constant SHALL NOT change SWITCH_CNT.
REQ-019 The block SHALL contain no other state.

Reset
REQ-020 While RST_N=0 at a rising CLK edge, the block SHALL set YQ=0, S1_prev=0 and SWITCH_CNT=0.
REQ-021 Y SHALL remain purely combinational and valid during reset.
REQ-022 A reset asserted mid-operation SHALL take effect at the next rising edge and SHALL override any increment in that cycle.
REQ-023 The first edge after reset release SHALL count a transition when S1=1, because S1_prev=0.

Configuration
REQ-024 With macro MUX_21_SWCNT_EN defined, the block SHALL include S1_prev, the counter and the SWITCH_CNT port.
REQ-025 Without MUX_21_SWCNT_EN, the counter logic and the SWITCH_CNT port SHALL be absent, and Y and YQ behaviour SHALL be unchanged.

Structure
REQ-026 Shared package mux_21_pkg SHALL hold the WIDTH_DEF=1 and CNT_W_DEF=8 constants and the data-word typedef.
REQ-027 The saturating transition counter SHALL be the single sub-module mux_21_swcnt, instantiated only under MUX_21_SWCNT_EN.

Verification
REQ-028 Truth-table sweep (WIDTH=1): apply {S1,D0,D1} = 000, 001, 010, 011, 100, 101, 110, 111, then 000, each held 20 ns -> Y = 0,0,1,1,0,1,0,1,0.
REQ-029 Registered path: with RST_N=1, set S1=1, D1=1, D0=0 -> Y=1 immediately, and YQ=1 after the next rising edge, not before.
REQ-030 Reset: drive RST_N=0 for 2 cycles with S1=1, D1=1 -> YQ=0, SWITCH_CNT=0, Y=1 throughout.
REQ-031 Counter: with CNT_W=2, toggle S1 every cycle for 5 cycles -> SWITCH_CNT = 1, 2, 3, 3, 3.
REQ-032 Build without MUX_21_SWCNT_EN, rerun REQ-028/REQ-029 -> identical Y/YQ results, and no SWITCH_CNT port.
REQ-033 WIDTH=8: D0=8'hA5, D1=8'h3C, S1=0 then 1 -> Y = 8'hA5 then 8'h3C.
